// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             bus_error,
    output logic             halted,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    // wait_cnt only has to reach MEM_TIMEOUT-1
    localparam int unsigned   WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WCW'(MEM_TIMEOUT - 1) : '0;

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [6:0]     op_q;
    logic [WCW-1:0] wait_cnt;
    logic           waiting;
    logic           timeout;
    logic           dec_exec;
    logic           dec_sys;
    logic           br_taken;

    assign waiting  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout  = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);

    assign dec_exec = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BR);
    assign dec_sys  = (opcode == OP_SYS);

    assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_HALT;
            end
            S_DECODE: begin
                if (dec_exec)     state_nxt = S_EXEC;
                else if (dec_sys) state_nxt = S_HALT;
                else              state_nxt = S_FETCH;
            end
            S_EXEC: begin
                if ((op_q == OP_R) || (op_q == OP_I))        state_nxt = S_WB;
                else if ((op_q == OP_LW) || (op_q == OP_SW)) state_nxt = S_MEM;
                else                                         state_nxt = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready)    state_nxt = (op_q == OP_SW) ? S_FETCH : S_WB;
                else if (timeout) state_nxt = S_HALT;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= opcode;
            wait_cnt <= ((state_nxt == state) && waiting) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Outputs are forced low throughout reset, so nothing leaks from the pre-reset state.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        bus_error  = 1'b0;
        halted     = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    bus_error = timeout;
                end
                S_DECODE: begin
                    illegal = !dec_exec && !dec_sys;
                end
                S_EXEC: begin
                    if ((op_q == OP_R) || (op_q == OP_I)) begin
                        alu_op  = 2'b10;
                        alu_src = (op_q == OP_I);
                    end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                        alu_op  = 2'b00;
                        alu_src = 1'b1;
                    end else begin
                        alu_op   = 2'b01;
                        pc_write = br_taken;
                        pc_src   = br_taken;
                    end
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    addr_src  = 1'b1;
                    mem_we    = (op_q == OP_SW);
                    bus_error = timeout;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LW);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_dbg = reset ? 3'd0 : state;

`ifdef PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ins_q;

    assign retire = (state == S_WB) ||
                    ((state == S_MEM) && mem_ready && (op_q == OP_SW)) ||
                    ((state == S_EXEC) && (op_q == OP_BR)) ||
                    ((state == S_DECODE) && !dec_exec && !dec_sys);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else if (state != S_HALT) begin
            cyc_q <= cyc_q + 1'b1;
            if (retire) ins_q <= ins_q + 1'b1;
        end
    end

    assign cycle_count = reset ? '0 : cyc_q;
    assign instr_count = reset ? '0 : ins_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle outputs; a negedge monitor compares them.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned TO = 16;
    localparam int unsigned CW = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_src, ir_write, pc_write, pc_src;
    logic          reg_write, mem_to_reg, alu_src, illegal, bus_error, halted;
    logic [1:0]    alu_op;
    logic [2:0]    state_dbg;
    logic [CW-1:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
        .bus_error(bus_error), .halted(halted), .state_dbg(state_dbg),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       illegal;
        logic       bus_error;
        logic       halted;
        logic [2:0] st;
    } ov_t;

    typedef struct {
        ov_t o;
        bit  rst;
        bit  ret;
    } ent_t;

    ent_t        sb[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned n_cyc = 0;

    function automatic ov_t st_only(input logic [2:0] s);
        ov_t v;
        v = '0;
        v.st = s;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic [2:0] r3();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic [6:0] op,
                        input logic [2:0] f3, input logic z, input ov_t e, input bit ret);
        ent_t x;
        reset = rst; mem_ready = rdy; opcode = op; funct3 = f3; zero = z;
        x.o = e; x.rst = rst; x.ret = ret;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, rb(), r7(), r3(), rb(), '0, 1'b0);
    endtask

    task automatic halt_cycles(input int n);
        ov_t e;
        e = st_only(3'd5);
        e.halted = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, rb(), r7(), r3(), rb(), e, 1'b0);
    endtask

    // result: 0 completed, 1 bus error (now halted)
    task automatic fetch_phase(input int fw, output int result);
        ov_t e;
        result = 0;
        for (int i = 0; i < fw; i++) begin
            e = st_only(3'd0);
            e.mem_req = 1'b1;
            if (i == TO - 1) begin
                e.bus_error = 1'b1;
                step(1'b0, 1'b0, r7(), r3(), rb(), e, 1'b0);
                result = 1;
                return;
            end
            step(1'b0, 1'b0, r7(), r3(), rb(), e, 1'b0);
        end
        e = st_only(3'd0);
        e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b0, 1'b1, r7(), r3(), rb(), e, 1'b0);
    endtask

    // result: 0 completed, 1 bus error, 2 reset applied mid-access
    task automatic mem_phase(input logic [6:0] op, input logic [2:0] f3, input bit is_sw,
                             input int mw, input int rst_at, output int result);
        ov_t e;
        result = 0;
        for (int i = 0; i < mw; i++) begin
            if (i == rst_at) begin
                step(1'b1, rb(), op, f3, rb(), '0, 1'b0);
                result = 2;
                return;
            end
            e = st_only(3'd3);
            e.mem_req = 1'b1; e.addr_src = 1'b1; e.mem_we = is_sw;
            if (i == TO - 1) begin
                e.bus_error = 1'b1;
                step(1'b0, 1'b0, op, f3, rb(), e, 1'b0);
                result = 1;
                return;
            end
            step(1'b0, 1'b0, op, f3, rb(), e, 1'b0);
        end
        e = st_only(3'd3);
        e.mem_req = 1'b1; e.addr_src = 1'b1; e.mem_we = is_sw;
        step(1'b0, 1'b1, op, f3, rb(), e, is_sw);
    endtask

    // Expands one instruction into its expected cycle sequence.
    // result: 0 back in FETCH, 1 halted, 2 reset applied
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, input int rst_at, output int result);
        ov_t e;
        int  kind;
        int  r;
        bit  taken;
        fetch_phase(fw, r);
        if (r != 0) begin result = 1; return; end
        case (op)
            OP_R:    kind = 0;
            OP_I:    kind = 1;
            OP_LW:   kind = 2;
            OP_SW:   kind = 3;
            OP_BR:   kind = 4;
            OP_SYS:  kind = 5;
            default: kind = 6;
        endcase
        e = st_only(3'd1);
        e.illegal = (kind == 6);
        step(1'b0, rb(), op, f3, rb(), e, kind == 6);
        if (kind == 6) begin result = 0; return; end
        if (kind == 5) begin result = 1; return; end
        e = st_only(3'd2);
        taken = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
        case (kind)
            0: e.alu_op = 2'b10;
            1: begin e.alu_op = 2'b10; e.alu_src = 1'b1; end
            2, 3: e.alu_src = 1'b1;
            default: begin e.alu_op = 2'b01; e.pc_write = taken; e.pc_src = taken; end
        endcase
        step(1'b0, rb(), op, f3, z, e, kind == 4);
        if (kind == 4) begin result = 0; return; end
        if (kind >= 2) begin
            mem_phase(op, f3, kind == 3, mw, rst_at, r);
            if (r != 0 || kind == 3) begin result = r; return; end
        end
        e = st_only(3'd4);
        e.reg_write = 1'b1; e.mem_to_reg = (kind == 2);
        step(1'b0, rb(), op, f3, rb(), e, 1'b1);
        result = 0;
    endtask

    ent_t          mx;
    ov_t           got;
    logic [CW-1:0] mdl_cc = '0;
    logic [CW-1:0] mdl_ic = '0;
    logic [CW-1:0] want_cc, want_ic;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mx  = sb.pop_front();
            got = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write,
                   mem_to_reg, alu_src, alu_op, illegal, bus_error, halted, state_dbg};
            n_cyc++;
            n_chk++;
            if (got === mx.o) n_pass++;
            else $display("FAIL outs cyc%0d rst=%0b got=%h exp=%h", n_cyc, mx.rst, got, mx.o);
`ifdef PERF_CNT_EN
            want_cc = mx.rst ? '0 : mdl_cc;
            want_ic = mx.rst ? '0 : mdl_ic;
`else
            want_cc = '0;
            want_ic = '0;
`endif
            n_chk++;
            if (cycle_count === want_cc && instr_count === want_ic) n_pass++;
            else $display("FAIL counters cyc%0d got=%0d/%0d exp=%0d/%0d",
                          n_cyc, cycle_count, instr_count, want_cc, want_ic);
            if (mx.rst) begin
                mdl_cc <= '0;
                mdl_ic <= '0;
            end else begin
                if (mx.o.st != 3'd5) mdl_cc <= mdl_cc + 1'b1;
                if (mx.ret) mdl_ic <= mdl_ic + 1'b1;
            end
        end
    end

    initial begin
        int res;
        int pick;
        logic [6:0] op;
        int fw, mw, rst_at;
        @(posedge clk); #1;
        do_reset(2);
        run_instr(OP_R, 3'd0, 1'b0, 0, 0, -1, res);
        run_instr(OP_LW, 3'd2, 1'b0, 0, 3, -1, res);
        run_instr(OP_BR, 3'b000, 1'b1, 0, 0, -1, res);
        run_instr(OP_BR, 3'b000, 1'b0, 0, 0, -1, res);
        run_instr(OP_BR, 3'b001, 1'b1, 0, 0, -1, res);
        run_instr(OP_BR, 3'b001, 1'b0, 0, 0, -1, res);
        run_instr(OP_BR, 3'b100, 1'b1, 1, 0, -1, res);
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, -1, res);
        run_instr(OP_I, 3'd0, 1'b0, TO - 1, 0, -1, res);
        run_instr(OP_SW, 3'd2, 1'b0, 0, TO - 1, -1, res);
        run_instr(OP_SYS, 3'd0, 1'b0, 0, 0, -1, res);
        halt_cycles(20);
        do_reset(2);
        run_instr(OP_R, 3'd0, 1'b0, TO, 0, -1, res);
        halt_cycles(4);
        do_reset(1);
        run_instr(OP_LW, 3'd2, 1'b0, 1, TO + 3, -1, res);
        halt_cycles(4);
        do_reset(1);
        run_instr(OP_LW, 3'd2, 1'b0, 0, 5, 2, res);
        run_instr(OP_SW, 3'd2, 1'b0, 2, 1, -1, res);

        for (int n = 0; n < 250; n++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 20)      op = OP_R;
            else if (pick < 38) op = OP_I;
            else if (pick < 54) op = OP_LW;
            else if (pick < 70) op = OP_SW;
            else if (pick < 88) op = OP_BR;
            else if (pick < 97) op = r7();
            else                op = OP_SYS;
            fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            rst_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(op, r3(), rb(), fw, mw, rst_at, res);
            if (res == 1) begin
                halt_cycles(int'($urandom_range(1, 5)));
                do_reset(int'($urandom_range(1, 3)));
            end
        end

        @(negedge clk); #1;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain left=%0d exp=0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
